// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 serial receiver with receive buffer for the OPC5 board system.
//   rxd is synchronised by two flops, deframed at CLKSPEED/BAUD and the
//   received byte is pushed into a first-word fall-through buffer.
//
//   Optional feature macro: UART_RX_FIFO_EN
//     defined   : 2**FIFO_LOG2-entry FIFO
//     undefined : single holding register, rx_full == rx_valid
//
//   Ports
//     clk       in   system clock, rising edge
//     reset     in   synchronous, active-high
//     rxd       in   asynchronous serial input, idle high
//     rd        in   pop strobe, one cycle per byte
//     clr_err   in   clears sticky error flags
//     rd_data   out  [7:0] head-of-buffer byte (0x00 when empty)
//     rx_valid  out  buffer non-empty
//     rx_full   out  buffer full
//     overrun   out  sticky: byte dropped because buffer full
//     frame_err out  sticky: stop bit sampled low
module uart_rx_fifo #(
    parameter int CLKSPEED  = 50000000,
    parameter int BAUD      = 115200,
    parameter int FIFO_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       overrun,
    output logic       frame_err
);

    localparam int DIV  = CLKSPEED / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser. Reset to 0 so a line held low through reset never
    // looks like a falling edge; a real 1->0 is needed after release.
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rxs_q;

    // ------------------------------------------------------------------
    // Deframing FSM
    // ------------------------------------------------------------------
    state_t          state_q,    state_d;
    logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_cnt_q,  bit_cnt_d;
    logic [7:0]      shift_q,    shift_d;
    logic            push_q,     push_d;
    logic            ferr_set_q, ferr_set_d;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        push_d     = 1'b0;
        ferr_set_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                // rx_meta_q is the value rxs_q takes at this edge, so the
                // START count begins on the edge where rxs falls.
                if (rxs_q && !rx_meta_q) begin
                    state_d    = ST_START;
                    baud_cnt_d = CW'(HALF - 1);
                end
            end
            ST_START: begin
                if (baud_cnt_q == '0) begin
                    if (!rxs_q) begin
                        state_d    = ST_DATA;
                        baud_cnt_d = CW'(DIV - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_cnt_q == '0) begin
                    shift_d    = {rxs_q, shift_q[7:1]};
                    baud_cnt_d = CW'(DIV - 1);
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_cnt_q == '0) begin
                    if (rxs_q) begin
                        push_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_set_d = 1'b1;
                        state_d    = ST_BREAK;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            ST_BREAK: begin
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b0;
            rxs_q      <= 1'b0;
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
        end else begin
            rx_meta_q  <= rxd;
            rxs_q      <= rx_meta_q;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            push_q     <= push_d;
            ferr_set_q <= ferr_set_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive buffer. shift_q is stable for many cycles after a push
    // strobe, so it is written directly.
    // ------------------------------------------------------------------
    logic do_pop;
    logic do_push;
    logic overrun_set;

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 2 ** FIFO_LOG2;
    localparam int CNTW  = FIFO_LOG2 + 1;

    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]      count_q,  count_d;
    logic                 full;

    assign full    = (count_q == CNTW'(DEPTH));
    assign do_pop  = rd && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds then.
    assign do_push = push_q && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rx_valid = (count_q != '0);
    assign rx_full  = full;
    assign rd_data  = rx_valid ? mem_q[rd_ptr_q] : '0;
`else
    logic [7:0] hold_q,  hold_d;
    logic       valid_q, valid_d;
    logic       unused_fifo_log2;

    // FIFO_LOG2 has no role with a single holding register.
    assign unused_fifo_log2 = (FIFO_LOG2 != 0);

    assign do_pop  = rd && valid_q;
    assign do_push = push_q && (!valid_q || do_pop);

    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        if (do_push) begin
            hold_d  = shift_q;
            valid_d = 1'b1;
        end else if (do_pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign rx_valid = valid_q;
    assign rx_full  = valid_q;
    assign rd_data  = valid_q ? hold_q : '0;
`endif

    assign overrun_set = push_q && !do_push;

    // ------------------------------------------------------------------
    // Sticky flags: a set event beats clr_err in the same cycle.
    // ------------------------------------------------------------------
    logic overrun_q,   overrun_d;
    logic frame_err_q, frame_err_d;

    always_comb begin
        overrun_d   = (overrun_q   && !clr_err) || overrun_set;
        frame_err_d = (frame_err_q && !clr_err) || ferr_set_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo at DIV=16, HALF=8. Covers the FIFO build or
// the holding-register build depending on UART_RX_FIFO_EN.
module tb_uart_rx_fifo;

    localparam int CLKSPEED = 1600000;
    localparam int BAUD     = 100000;
`ifdef UART_RX_FIFO_EN
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam bit FIFO_MODE = 1'b0;
`endif
    localparam bit HF = !FIFO_MODE;   // rx_full with one byte held

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rd;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       rx_full;
    logic       overrun;
    logic       frame_err;

    uart_rx_fifo #(
        .CLKSPEED (CLKSPEED),
        .BAUD     (BAUD),
        .FIFO_LOG2(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rd       (rd),
        .clr_err  (clr_err),
        .rd_data  (rd_data),
        .rx_valid (rx_valid),
        .rx_full  (rx_full),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   fall_cyc = 0;
    int   rise_cyc = -1;
    logic last_v   = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && !last_v) rise_cyc = cyc;
        last_v = rx_valid;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [7:0] d, input logic v,
                              input logic f, input logic o, input logic e);
        check({name, " rd_data"},   rd_data,   d);
        check({name, " rx_valid"},  rx_valid,  v);
        check({name, " rx_full"},   rx_full,   f);
        check({name, " overrun"},   overrun,   o);
        check({name, " frame_err"}, frame_err, e);
    endtask

    // All bench actions happen 1 time unit after a rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int extra_low);
        rxd      = 1'b0;
        fall_cyc = cyc;
        wait_cycles(16);
        for (int b = 0; b < 8; b++) begin
            rxd = d[b];
            wait_cycles(16);
        end
        rxd = stop;
        wait_cycles(16);
        if (!stop && extra_low > 0) begin
            rxd = 1'b0;
            wait_cycles(extra_low);
        end
        rxd = 1'b1;
        wait_cycles(8);
    endtask

    task automatic pop();
        rd = 1'b1;
        wait_cycles(1);
        rd = 1'b0;
        wait_cycles(1);
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        wait_cycles(1);
        clr_err = 1'b0;
        wait_cycles(1);
    endtask

    // Sends d and raises rd for exactly the cycle in which d is pushed.
    task automatic send_with_pop(input logic [7:0] d);
        fork
            send_byte(d, 1'b1, 0);
            begin
                wait_cycles(154);
                rd = 1'b1;
                wait_cycles(1);
                rd = 1'b0;
            end
        join
    endtask

    typedef struct {
        bit         send;
        logic [7:0] data;
        bit         stop;
        int         extra_low;
        logic [7:0] e_data;
        bit         e_v;
        bit         e_f;
        bit         e_o;
        bit         e_e;
        bit         do_pop;
        bit         do_clr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1, 8'h3C, 1, 0,  8'h3C, 1, HF, 0, 0, 1, 0};
        tbl[1] = '{0, 8'h00, 1, 0,  8'h00, 0, 0,  0, 0, 0, 0};
        tbl[2] = '{1, 8'h00, 0, 40, 8'h00, 0, 0,  0, 1, 0, 0};
        tbl[3] = '{1, 8'h81, 1, 0,  8'h81, 1, HF, 0, 1, 0, 1};
        tbl[4] = '{0, 8'h00, 1, 0,  8'h81, 1, HF, 0, 0, 1, 0};
        tbl[5] = '{1, 8'h11, 1, 0,  8'h11, 1, HF, 0, 0, 0, 0};
`ifdef UART_RX_FIFO_EN
        tbl[6] = '{1, 8'h22, 1, 0,  8'h11, 1, 0,  0, 0, 1, 0};
        tbl[7] = '{0, 8'h00, 1, 0,  8'h22, 1, 0,  0, 0, 1, 0};
        tbl[8] = '{0, 8'h00, 1, 0,  8'h00, 0, 0,  0, 0, 0, 0};
`else
        tbl[6] = '{1, 8'h22, 1, 0,  8'h11, 1, 1,  1, 0, 1, 0};
        tbl[7] = '{0, 8'h00, 1, 0,  8'h00, 0, 0,  1, 0, 0, 1};
        tbl[8] = '{0, 8'h00, 1, 0,  8'h00, 0, 0,  0, 0, 0, 0};
`endif

        reset   = 1'b1;
        rxd     = 1'b1;
        rd      = 1'b0;
        clr_err = 1'b0;
        wait_cycles(3);
        check_outs("in_reset", 8'h00, 0, 0, 0, 0);
        reset = 1'b0;
        wait_cycles(4);
        check_outs("after_reset", 8'h00, 0, 0, 0, 0);

        // First character and its latency from the rxd falling edge.
        send_byte(8'hA5, 1'b1, 0);
        check("latency", rise_cyc - fall_cyc, 155);
        check_outs("a5", 8'hA5, 1, HF, 0, 0);
        pop();
        check_outs("a5_pop", 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].send) send_byte(tbl[i].data, tbl[i].stop, tbl[i].extra_low);
            else             wait_cycles(4);
            check_outs($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_v,
                       tbl[i].e_f, tbl[i].e_o, tbl[i].e_e);
            if (tbl[i].do_pop) pop();
            if (tbl[i].do_clr) clear_err();
        end

`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 0);
        check_outs("fill16", 8'h00, 1, 1, 0, 0);
        send_byte(8'h10, 1'b1, 0);
        check_outs("push17", 8'h00, 1, 1, 1, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), rd_data, 8'(i));
            pop();
        end
        check_outs("drained", 8'h00, 0, 0, 1, 0);
        clear_err();
        check("ovr_clr", overrun, 1'b0);

        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1, 0);
        send_with_pop(8'h30);
        check_outs("pushpop_full", 8'h21, 1, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("pp_drain%0d", i), rd_data, 8'(8'h21 + i));
            pop();
        end
        check("pp_empty", rx_valid, 1'b0);
`else
        send_byte(8'h20, 1'b1, 0);
        send_with_pop(8'h30);
        check_outs("pushpop_hold", 8'h30, 1, 1, 0, 0);
        pop();
        check("pp_empty", rx_valid, 1'b0);
`endif

        // Short low glitch on an idle line.
        rxd = 1'b0;
        wait_cycles(4);
        rxd = 1'b1;
        wait_cycles(40);
        check_outs("glitch", 8'h00, 0, 0, 0, 0);
        send_byte(8'h3C, 1'b1, 0);
        check_outs("post_glitch", 8'h3C, 1, HF, 0, 0);
        pop();

        // Reset in the middle of a character with the line held low.
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b1, 0);
        check("pre_rst_valid", rx_valid, 1'b1);
        rxd = 1'b0;
        wait_cycles(60);
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(1);
        check_outs("mid_rst", 8'h00, 0, 0, 0, 0);
        wait_cycles(200);
        check_outs("held_low", 8'h00, 0, 0, 0, 0);
        rxd = 1'b1;
        wait_cycles(10);
        send_byte(8'h5A, 1'b1, 0);
        check_outs("post_rst", 8'h5A, 1, HF, 0, 0);
        pop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
